uart_rx: RTL and testbench

// - Receive half of the UART link: samples serial line ser_rx, recovers 8N1 frames (LSB first), emits one byte per frame.
// - Pairs with the existing transmitter (uart_top); on iCE40 it sits on SER_RX behind the 24 MHz PLL clock.
// - Drives LEDs / downstream consumers via a one-cycle out_valid strobe.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch reject and line-break handling.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity checked, errors reported at stop).
module uart_rx #(
  parameter int clocks_per_bit = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_error,
  output logic       busy
);

  localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(clocks_per_bit - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(clocks_per_bit / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sr;
  logic          rx_p0, rx_s;
  logic          shift_en, valid_n, error_n, good_stop;
`ifdef UART_RX_PARITY_EN
  logic          perr, perr_n;
`endif

  // input synchronizer stage: ser_rx -> rx_p0 -> rx_s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= ser_rx;
      rx_s  <= rx_p0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign good_stop = rx_s && !perr;
`else
  assign good_stop = rx_s;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    shift_en = 1'b0;
    valid_n  = 1'b0;
    error_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n   = perr;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef UART_RX_PARITY_EN
        perr_n = 1'b0;
`endif
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          idx_n = '0;
          // A start bit that is high again at its midpoint was a glitch
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          shift_en = 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          perr_n  = ((^sr) != rx_s);
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (good_stop) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            error_n = 1'b1;
            state_n = rx_s ? IDLE : BRK;
          end
        end
      end
      BRK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // control / output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      out_data  <= 8'h00;
`ifdef UART_RX_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      out_valid <= valid_n;
      out_error <= error_n;
      if (valid_n) out_data <= sr;
`ifdef UART_RX_PARITY_EN
      perr      <= perr_n;
`endif
    end
  end

  // shift register stage, LSB arrives first
  always_ff @(posedge clk) begin
    if (shift_en) sr <= {rx_s, sr[7:1]};
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at clocks_per_bit=8.
// Expected events are queued by the frame driver and matched by an independent monitor.
module tb_uart_rx;
  localparam int P = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS_AFTER_START = 10;
`else
  localparam int NBITS_AFTER_START = 9;
`endif
  // Strobe visible at the negedge this many cycles after the negedge that drove the start bit
  localparam int LAT = 3 + P / 2 + NBITS_AFTER_START * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_rx = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_error, busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.clocks_per_bit(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .ser_rx   (ser_rx),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_error(out_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (out_valid || out_error)) begin
      check("strobe_exclusive", int'(out_valid && out_error), 0);
      if (q.size() == 0) begin
        check("unexpected_strobe", int'({out_valid, out_error}), 0);
      end else begin
        e = q.pop_front();
        check("strobe_kind", int'(out_error), int'(e.is_err));
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_data", int'(out_data), int'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge. abort_bit >= 0 stops mid data bit abort_bit.
  task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                      input int low_hold, input int abort_bit);
    exp_t e;
    bit   good;
    good = stop_ok;
`ifdef UART_RX_PARITY_EN
    good = stop_ok && par_ok;
`endif
    if (abort_bit < 0) begin
      e.is_err = !good;
      e.data   = good ? d : last_good;
      e.cyc    = cyc + LAT;
      q.push_back(e);
      if (good) last_good = d;
    end
    ser_rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      if (i == abort_bit) begin
        repeat (P / 2) @(negedge clk);
        return;
      end
      repeat (P) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    ser_rx = (^d) ^ !par_ok;
    repeat (P) @(negedge clk);
`endif
    ser_rx = stop_ok;
    repeat (P) @(negedge clk);
    if (!stop_ok) begin
      repeat (low_hold) @(negedge clk);
      idle(P);
    end
    ser_rx = 1'b1;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle(200);
    check("idle_valid", int'(out_valid), 0);
    check("idle_error", int'(out_error), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_data", int'(out_data), 8'h00);

    send(8'hA5, 1'b1, 1'b1, 0, -1);
    idle(4);
    check("a5_data_held", int'(out_data), 8'hA5);
    send(8'h00, 1'b1, 1'b1, 0, -1);
    send(8'hFF, 1'b1, 1'b1, 0, -1);
    idle(P);

    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(3 * P);
    check("glitch_busy", int'(busy), 0);
    check("glitch_data", int'(out_data), 8'hFF);

    send(8'h3C, 1'b0, 1'b1, 40, -1);
    idle(4);
    check("break_busy", int'(busy), 0);
    check("break_data", int'(out_data), 8'hFF);
    send(8'h81, 1'b1, 1'b1, 0, -1);
    idle(P);

    send(8'h55, 1'b1, 1'b1, 0, 4);
    rst = 1'b1;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_error", int'(out_error), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(out_data), 8'h00);
    last_good = 8'h00;
    @(negedge clk);
    ser_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2 * P);
    send(8'h55, 1'b1, 1'b1, 0, -1);
    idle(P);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 0, -1);
    send(8'h07, 1'b1, 1'b0, 0, -1);
    idle(P);
`endif

    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      idle($urandom_range(0, 12));
      send(d, $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 30), -1);
    end

    guard = 0;
    while (q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("queue_drained", q.size(), 0);
    idle(4);
    check("final_busy", int'(busy), 0);
    check("final_data", int'(out_data), int'(last_good));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
